q_pipe_buffer: RTL and testbench
================================

Q_PIPE_BUFFER -- requirements
Module: q_pipe_buffer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data bits per token.
REQ-002 The block SHALL have parameter DEPTH, default 4: buffer slots, a power of two and at least 2.
REQ-003 The block SHALL have parameter SYNC, default 2: synchronizer flops on each asynchronous handshake input, at least 2.
REQ-004 The block SHALL have parameter TWO_PHASE, default 0: 0 selects 4-phase return-to-zero handshakes, 1 selects 2-phase transition handshakes, applied to both sides.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-007 The block SHALL have port r_in, input, 1 bit: upstream request, asynchronous to clk.
REQ-008 The block SHALL have port d_in, input, WIDTH bits: upstream bundled data, stable while r_in is pending.
REQ-009 The block SHALL have port a_in, output, 1 bit: upstream acknowledge.
REQ-010 The block SHALL have port r_out, output, 1 bit: downstream request.
REQ-011 The block SHALL have port d_out, output, WIDTH bits: downstream data, stable while r_out is pending.
REQ-012 The block SHALL have port a_out, input, 1 bit: downstream acknowledge, asynchronous to clk.
REQ-013 The block SHALL have port full, output, 1 bit: asserted when count equals DEPTH.
REQ-014 The block SHALL have port empty, output, 1 bit: asserted when count equals 0.
REQ-015 The block SHALL have port count, output, clog2(DEPTH+1) bits: number of occupied slots.

Function
REQ-016 r_in and a_out SHALL each pass through a SYNC-flop synchronizer; all handshake decisions SHALL use only the synchronized values rs and as.
REQ-017 The storage SHALL be a circular buffer with wr_ptr and rd_ptr of clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-018 In 4-phase mode, the input FSM SHALL leave IN_IDLE for IN_HOLD when rs=1 and full=0, writing d_in at wr_ptr, incrementing wr_ptr and registering a_in=1.
REQ-019 In 4-phase mode, the input FSM SHALL return from IN_HOLD to IN_IDLE when rs=0, registering a_in=0.
REQ-020 In 2-phase mode, a write SHALL occur when rs differs from a_in and full=0, and that write SHALL toggle a_in.
REQ-021 A request arriving while full=1 SHALL be held with no acknowledge until a slot frees; it SHALL then be accepted no earlier than the cycle after the pop.
REQ-022 In 4-phase mode, the output FSM SHALL move from OUT_IDLE to OUT_REQ when empty=0, registering d_out equal to the entry at rd_ptr and r_out=1.
REQ-023 In 4-phase mode, the output FSM SHALL move from OUT_REQ to OUT_RTZ when as=1, popping the entry, incrementing rd_ptr and registering r_out=0.
REQ-024 In 4-phase mode, the output FSM SHALL move from OUT_RTZ to OUT_IDLE when as=0.
REQ-025 In 2-phase mode, the block SHALL be idle when r_out equals as; when idle with empty=0 it SHALL register d_out from the head and toggle r_out.
REQ-026 In 2-phase mode, the block SHALL pop when as becomes equal to r_out again.
REQ-027 A push and a pop in the same cycle SHALL both take effect and leave count unchanged; full and empty SHALL be derived from the registered count before that cycle's update.
REQ-028 d_out SHALL change only on the cycle r_out is asserted (4-phase) or toggled (2-phase).
REQ-029 Latency SHALL be SYNC+1 clk cycles from an r_in edge to the a_in response; with the buffer empty, r_out SHALL assert or toggle on the cycle after the write.
REQ-030 full, empty and count SHALL be registered outputs.

Reset
REQ-031 Assertion of rst (low) SHALL immediately clear a_in, r_out, d_out, count, both pointers and all synchronizer flops; it SHALL set empty=1 and full=0, and place both FSMs in idle.
REQ-032 A reset during a transfer SHALL discard all buffered tokens; peers are responsible for restarting their handshakes.
REQ-033 Buffer contents SHALL NOT require reset.

Structure
REQ-034 The package q_pipe_pkg SHALL hold the in-state and out-state typedefs and the PHASE_4 and PHASE_2 mode constants.
REQ-035 Synchronization SHALL be implemented as sub-module q_sync, parameter SYNC, instantiated twice (r_in, a_out).

Verification
REQ-036 4-phase mode, DEPTH=4, send tokens 0x11, 0x22, 0x33 with a_out echoing r_out -> d_out sequence 0x11, 0x22, 0x33; a_in rises SYNC+1=3 cycles after each r_in rise.
REQ-037 4-phase mode, hold a_out=0, send 5 tokens -> full=1 and count=4 after the 4th; the 5th r_in gets no a_in until one a_out cycle completes, then it is accepted.
REQ-038 2-phase mode, send 6 tokens with a random acknowledge delay of 0-5 cycles -> in-order delivery, one r_out toggle per token, pointers wrap once.
REQ-039 Full buffer, with the push and the pop aligned to the same cycle -> count stays 4 and no data is lost or duplicated.
REQ-040 Assert rst with count=2 in OUT_REQ -> a_in=0, r_out=0, empty=1 and count=0 within the same cycle; a fresh token 0x5A afterwards is delivered normally.

Source files
------------

// File: rtl/q_pipe_pkg.sv
// Shared types for the self-timed pipeline buffer: FSM state encodings and handshake mode selectors.
// No logic lives here.
package q_pipe_pkg;

  localparam int PHASE_4 = 0;
  localparam int PHASE_2 = 1;

  typedef enum logic {
    IN_IDLE,
    IN_HOLD
  } in_state_t;

  typedef enum logic [1:0] {
    OUT_IDLE,
    OUT_REQ,
    OUT_RTZ
  } out_state_t;

endpackage

// File: rtl/q_sync.sv
// Multi-flop synchronizer that brings an asynchronous handshake wire into clk.
// Latency SYNC cycles; no backpressure.
module q_sync #(
  parameter int SYNC = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC-1:0] ff;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff <= '0;
    end else begin
      ff <= {ff[SYNC-2:0], d};
    end
  end

  assign q = ff[SYNC-1];

endmodule

// File: rtl/q_pipe_buffer.sv
// Circular buffer bridging an asynchronous req/ack producer to an asynchronous req/ack consumer.
// Latency SYNC+1 from r_in edge to a_in; a full buffer withholds a_in until a slot frees.
module q_pipe_buffer
  import q_pipe_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int SYNC      = 2,
  parameter int TWO_PHASE = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       r_in,
  input  logic [WIDTH-1:0]           d_in,
  output logic                       a_in,
  output logic                       r_out,
  output logic [WIDTH-1:0]           d_out,
  input  logic                       a_out,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam bit TP = (TWO_PHASE == PHASE_2);

  logic rs;
  logic as;

  q_sync #(.SYNC(SYNC)) u_sync_req (.clk(clk), .rst(rst), .d(r_in),  .q(rs));
  q_sync #(.SYNC(SYNC)) u_sync_ack (.clk(clk), .rst(rst), .d(a_out), .q(as));

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;

  in_state_t  in_state,  in_state_nxt;
  out_state_t out_state, out_state_nxt;
  logic       a_in_nxt;
  logic       r_out_nxt;
  logic       push;
  logic       pop;
  logic       load;

  // Input side: decisions use the registered full flag, so a slot freed by a pop
  // becomes visible to the producer one cycle later.
  always_comb begin
    in_state_nxt = in_state;
    a_in_nxt     = a_in;
    push         = 1'b0;
    if (TP) begin
      if ((rs != a_in) && !full) begin
        push     = 1'b1;
        a_in_nxt = ~a_in;
      end
    end else begin
      case (in_state)
        IN_IDLE: if (rs && !full) begin
          push         = 1'b1;
          a_in_nxt     = 1'b1;
          in_state_nxt = IN_HOLD;
        end
        IN_HOLD: if (!rs) begin
          a_in_nxt     = 1'b0;
          in_state_nxt = IN_IDLE;
        end
        default: in_state_nxt = IN_IDLE;
      endcase
    end
  end

  // Output side: d_out is loaded only when a new request is issued.
  always_comb begin
    out_state_nxt = out_state;
    r_out_nxt     = r_out;
    load          = 1'b0;
    pop           = 1'b0;
    if (TP) begin
      case (out_state)
        OUT_IDLE: if (!empty) begin
          load          = 1'b1;
          r_out_nxt     = ~r_out;
          out_state_nxt = OUT_REQ;
        end
        OUT_REQ: if (as == r_out) begin
          pop           = 1'b1;
          out_state_nxt = OUT_IDLE;
        end
        default: out_state_nxt = OUT_IDLE;
      endcase
    end else begin
      case (out_state)
        OUT_IDLE: if (!empty) begin
          load          = 1'b1;
          r_out_nxt     = 1'b1;
          out_state_nxt = OUT_REQ;
        end
        OUT_REQ: if (as) begin
          pop           = 1'b1;
          r_out_nxt     = 1'b0;
          out_state_nxt = OUT_RTZ;
        end
        OUT_RTZ: if (!as) begin
          out_state_nxt = OUT_IDLE;
        end
        default: out_state_nxt = OUT_IDLE;
      endcase
    end
  end

  assign count_nxt = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_state  <= IN_IDLE;
      out_state <= OUT_IDLE;
      a_in      <= 1'b0;
      r_out     <= 1'b0;
      d_out     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
    end else begin
      in_state  <= in_state_nxt;
      out_state <= out_state_nxt;
      a_in      <= a_in_nxt;
      r_out     <= r_out_nxt;
      if (load) d_out <= mem[rd_ptr];
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count     <= count_nxt;
      full      <= (count_nxt == DEPTH_C);
      empty     <= (count_nxt == '0);
    end
  end

  // Storage holds no state that matters after reset, so it is left unreset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= d_in;
  end

endmodule

// File: tb/tb_q_pipe_buffer.sv
// Directed bench for q_pipe_buffer: one 4-phase and one 2-phase instance share clock and reset.
module tb_q_pipe_buffer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  int         total = 0;
  int         bad = 0;

  logic       r4 = 1'b0, a4, ro4, ao4 = 1'b0, full4, empty4;
  logic [7:0] d4 = '0, do4;
  logic [2:0] cnt4;
  logic       r2 = 1'b0, a2, ro2, ao2 = 1'b0, full2, empty2;
  logic [7:0] d2 = '0, do2;
  logic [2:0] cnt2;

  always #5 clk = ~clk;

  q_pipe_buffer #(.WIDTH(8), .DEPTH(4), .SYNC(2), .TWO_PHASE(0)) dut4 (
    .clk(clk), .rst(rst), .r_in(r4), .d_in(d4), .a_in(a4), .r_out(ro4), .d_out(do4),
    .a_out(ao4), .full(full4), .empty(empty4), .count(cnt4));

  q_pipe_buffer #(.WIDTH(8), .DEPTH(4), .SYNC(2), .TWO_PHASE(1)) dut2 (
    .clk(clk), .rst(rst), .r_in(r2), .d_in(d2), .a_in(a2), .r_out(ro2), .d_out(do2),
    .a_out(ao2), .full(full2), .empty(empty2), .count(cnt2));

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "simulation time limit reached");
  end

  // 4-phase producer: full handshake for one token; lat counts clk edges to a_in rise.
  task automatic send4(input logic [7:0] v, output int lat, output bit to);
    @(negedge clk);
    d4 = v; r4 = 1'b1; lat = 0; to = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (a4 === 1'b1) begin lat = i; to = 1'b0; break; end
    end
    @(negedge clk);
    r4 = 1'b0;
    for (int i = 0; i < 40 && a4 !== 1'b0; i++) @(negedge clk);
    if (a4 !== 1'b0) to = 1'b1;
  endtask

  // 4-phase consumer: waits for r_out, captures d_out, completes the return-to-zero.
  task automatic recv4(output logic [7:0] v, output bit to);
    to = 1'b0; v = '0;
    for (int i = 0; i < 80 && ro4 !== 1'b1; i++) @(negedge clk);
    if (ro4 !== 1'b1) begin to = 1'b1; return; end
    v = do4; ao4 = 1'b1;
    for (int i = 0; i < 40 && ro4 !== 1'b0; i++) @(negedge clk);
    if (ro4 !== 1'b0) to = 1'b1;
    ao4 = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); #1;
    total++; if (a4 !== 1'b0)    begin bad++; $display("FAIL reset_a_in got=%b exp=0", a4); end
    total++; if (ro4 !== 1'b0)   begin bad++; $display("FAIL reset_r_out got=%b exp=0", ro4); end
    total++; if (do4 !== 8'h00)  begin bad++; $display("FAIL reset_d_out got=%h exp=00", do4); end
    total++; if (cnt4 !== 3'd0)  begin bad++; $display("FAIL reset_count got=%0d exp=0", cnt4); end
    total++; if (empty4 !== 1'b1 || full4 !== 1'b0) begin
      bad++; $display("FAIL reset_flags got empty=%b full=%b exp empty=1 full=0", empty4, full4);
    end
    total++; if (a2 !== 1'b0 || ro2 !== 1'b0 || empty2 !== 1'b1 || cnt2 !== 3'd0) begin
      bad++; $display("FAIL reset_2ph got a_in=%b r_out=%b empty=%b count=%0d", a2, ro2, empty2, cnt2);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_4ph_stream();
    logic [7:0] tok [3] = '{8'h11, 8'h22, 8'h33};
    logic [7:0] got [3];
    int lat [3];
    bit sto [3];
    bit rto [3];
    fork
      for (int k = 0; k < 3; k++) send4(tok[k], lat[k], sto[k]);
      for (int k = 0; k < 3; k++) recv4(got[k], rto[k]);
    join
    for (int k = 0; k < 3; k++) begin
      total++;
      if (sto[k] || lat[k] != 3) begin
        bad++; $display("FAIL stream_latency[%0d] got=%0d exp=3 timeout=%0d", k, lat[k], sto[k]);
      end
      total++;
      if (rto[k] || got[k] !== tok[k]) begin
        bad++; $display("FAIL stream_data[%0d] got=%h exp=%h timeout=%0d", k, got[k], tok[k], rto[k]);
      end
    end
    repeat (6) @(negedge clk);
    total++; if (empty4 !== 1'b1 || cnt4 !== 3'd0) begin
      bad++; $display("FAIL stream_drained got empty=%b count=%0d exp empty=1 count=0", empty4, cnt4);
    end
  endtask

  task automatic test_full_hold();
    logic [7:0] exp_q [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hA5};
    logic [7:0] v;
    int lat, pop_c, acc_c;
    bit to, any_to, early;
    any_to = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send4(8'hA1 + 8'(k), lat, to);
      any_to |= to;
    end
    total++; if (any_to) begin bad++; $display("FAIL full_fill got=timeout exp=4 acks"); end
    repeat (2) @(negedge clk);
    total++; if (full4 !== 1'b1 || cnt4 !== 3'd4) begin
      bad++; $display("FAIL full_flag got full=%b count=%0d exp full=1 count=4", full4, cnt4);
    end
    d4 = 8'hA5; r4 = 1'b1; early = 1'b0;
    for (int c = 0; c < 12; c++) begin @(posedge clk); #1; if (a4 !== 1'b0) early = 1'b1; end
    total++; if (early) begin bad++; $display("FAIL full_held got a_in=1 exp a_in=0 while full"); end
    @(negedge clk);
    pop_c = -1; acc_c = -1;
    fork
      recv4(v, to);
      for (int c = 0; c < 100; c++) begin
        @(posedge clk); #1;
        if (pop_c < 0 && cnt4 == 3'd3) pop_c = c;
        if (a4 === 1'b1) begin acc_c = c; break; end
      end
    join
    total++; if (to || v !== 8'hA1) begin
      bad++; $display("FAIL full_head got=%h exp=a1 timeout=%0d", v, to);
    end
    total++; if (pop_c < 0 || acc_c < 0 || acc_c - pop_c < 1) begin
      bad++; $display("FAIL full_accept got pop_cycle=%0d ack_cycle=%0d exp ack after pop", pop_c, acc_c);
    end
    @(negedge clk);
    r4 = 1'b0;
    for (int i = 0; i < 40 && a4 !== 1'b0; i++) @(negedge clk);
    total++; if (cnt4 !== 3'd4 || a4 !== 1'b0) begin
      bad++; $display("FAIL full_refill got count=%0d a_in=%b exp count=4 a_in=0", cnt4, a4);
    end
    for (int k = 0; k < 4; k++) begin
      recv4(v, to);
      total++;
      if (to || v !== exp_q[k]) begin
        bad++; $display("FAIL full_drain[%0d] got=%h exp=%h timeout=%0d", k, v, exp_q[k], to);
      end
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] exp_b [4] = '{8'hB2, 8'hB3, 8'hB4, 8'hB5};
    logic [7:0] v;
    int lat, mx, mn;
    bit to, any_to;
    any_to = 1'b0;
    for (int k = 0; k < 4; k++) begin send4(8'hB1 + 8'(k), lat, to); any_to |= to; end
    @(negedge clk);
    d4 = 8'hB5; r4 = 1'b1; ao4 = 1'b1; mx = 0;
    for (int c = 0; c < 10; c++) begin @(posedge clk); #1; if (int'(cnt4) > mx) mx = int'(cnt4); end
    total++; if (any_to || mx != 4 || cnt4 !== 3'd4 || a4 !== 1'b1) begin
      bad++; $display("FAIL same_full got max=%0d count=%0d a_in=%b exp max=4 count=4 a_in=1", mx, cnt4, a4);
    end
    @(negedge clk);
    r4 = 1'b0; ao4 = 1'b0;
    for (int i = 0; i < 40 && a4 !== 1'b0; i++) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      recv4(v, to);
      total++;
      if (to || v !== exp_b[k]) begin
        bad++; $display("FAIL same_full_drain[%0d] got=%h exp=%h timeout=%0d", k, v, exp_b[k], to);
      end
    end
    send4(8'hC1, lat, to); any_to = to;
    send4(8'hC2, lat, to); any_to |= to;
    @(negedge clk);
    d4 = 8'hC3; r4 = 1'b1; ao4 = 1'b1; mx = 0; mn = 7;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (int'(cnt4) > mx) mx = int'(cnt4);
      if (int'(cnt4) < mn) mn = int'(cnt4);
    end
    total++; if (any_to || mx != 2 || mn != 2 || a4 !== 1'b1 || ro4 !== 1'b0) begin
      bad++; $display("FAIL same_cycle got min=%0d max=%0d a_in=%b r_out=%b exp count 2 a_in=1 r_out=0", mn, mx, a4, ro4);
    end
    @(negedge clk);
    r4 = 1'b0; ao4 = 1'b0;
    for (int i = 0; i < 40 && a4 !== 1'b0; i++) @(negedge clk);
    recv4(v, to);
    total++; if (to || v !== 8'hC2) begin bad++; $display("FAIL same_drain0 got=%h exp=c2", v); end
    recv4(v, to);
    total++; if (to || v !== 8'hC3) begin bad++; $display("FAIL same_drain1 got=%h exp=c3", v); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    int lat;
    bit to, to2;
    send4(8'hD1, lat, to);
    @(negedge clk);
    d4 = 8'hD2; r4 = 1'b1;
    for (int i = 0; i < 40 && a4 !== 1'b1; i++) @(negedge clk);
    total++; if (to || a4 !== 1'b1 || ro4 !== 1'b1 || cnt4 !== 3'd2) begin
      bad++; $display("FAIL rstmid_setup got a_in=%b r_out=%b count=%0d exp 1 1 2", a4, ro4, cnt4);
    end
    #2 rst = 1'b0; r4 = 1'b0;
    #1;
    total++; if (a4 !== 1'b0 || ro4 !== 1'b0 || empty4 !== 1'b1 || cnt4 !== 3'd0 || do4 !== 8'h00) begin
      bad++; $display("FAIL rstmid_clear got a_in=%b r_out=%b empty=%b count=%0d d_out=%h", a4, ro4, empty4, cnt4, do4);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    send4(8'h5A, lat, to);
    recv4(v, to2);
    total++; if (to || to2 || lat != 3 || v !== 8'h5A) begin
      bad++; $display("FAIL rstmid_fresh got=%h lat=%0d exp=5a lat=3 timeout=%0d/%0d", v, lat, to, to2);
    end
  endtask

  task automatic test_2phase();
    logic [7:0] tok [6] = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
    logic [7:0] got [6];
    logic prev;
    int n, tg;
    bit tx_to;
    n = 0; tg = 0; tx_to = 1'b0; prev = ro2;
    fork
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        d2 = tok[k]; r2 = ~r2;
        for (int i = 0; i < 200 && a2 !== r2; i++) @(negedge clk);
        if (a2 !== r2) tx_to = 1'b1;
      end
      for (int c = 0; c < 800 && n < 6; c++) begin
        @(negedge clk);
        if (ro2 !== prev) begin
          tg++; prev = ro2; got[n] = do2;
          repeat ($urandom_range(0, 5)) @(negedge clk);
          ao2 = ro2; n++;
        end
      end
    join
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (ro2 !== prev) begin tg++; prev = ro2; end
    end
    total++; if (tx_to || n != 6) begin bad++; $display("FAIL p2_complete got tokens=%0d exp=6 tx_timeout=%0d", n, tx_to); end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (k < n && got[k] !== tok[k]) begin
        bad++; $display("FAIL p2_data[%0d] got=%h exp=%h", k, got[k], tok[k]);
      end
    end
    total++; if (tg != 6) begin bad++; $display("FAIL p2_toggles got=%0d exp=6", tg); end
    total++; if (dut2.wr_ptr !== 2'd2 || dut2.rd_ptr !== 2'd2 || empty2 !== 1'b1 || cnt2 !== 3'd0) begin
      bad++; $display("FAIL p2_wrap got wr=%0d rd=%0d empty=%b count=%0d exp 2 2 1 0", dut2.wr_ptr, dut2.rd_ptr, empty2, cnt2);
    end
  endtask

  initial begin
    test_reset();
    test_4ph_stream();
    test_full_hold();
    test_same_cycle();
    test_reset_mid();
    test_2phase();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
